// File: rtl/rd_burst_pkg.sv
// Shared types and helpers for the read-burst master: FSM state encoding,
// bus length width and the byte-to-beat conversion used at request latch.
package rd_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } rd_burst_state_t;

    localparam int AR_LEN_W = 8;
    localparam int TOTAL_W  = 16;

    // A zero-byte request still moves one beat so the requester always sees rd_done.
    function automatic logic [TOTAL_W-1:0] ceilBeats(input logic [15:0] lenBytes,
                                                     input int unsigned bytesPerBeat);
        logic [16:0] sum;
        sum = {1'b0, lenBytes} + 17'(bytesPerBeat - 1);
        if (lenBytes == 16'd0) begin
            ceilBeats = TOTAL_W'(1);
        end else begin
            ceilBeats = TOTAL_W'(sum / 17'(bytesPerBeat));
        end
    endfunction

endpackage

// File: rtl/rd_burst_master_fifo.sv
// Return-data FIFO for the read-burst master: each entry holds one bus beat
// plus a tag bit marking the final beat of the request.
module rd_data_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_popData,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wrPtr;
    logic [PTR_W:0]   r_rdPtr;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[PTR_W-1:0]] <= i_pushData;
        end
    end

    assign o_empty   = (r_wrPtr == r_rdPtr);
    assign o_full    = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                       (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
    assign o_popData = r_mem[r_rdPtr[PTR_W-1:0]];

endmodule

// File: rtl/rd_burst_master.sv
// Read-side burst master: splits one line read into AR bursts and streams the
// returned beats upstream. Define RD_BURST_PROTO_CHK_EN to enable the r_last check.
module rd_burst_master
    import rd_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rd_req,
    output logic                  o_rd_gnt,
    input  logic [15:0]           i_rd_len,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic                  o_rd_done,
    output logic                  o_ar_valid,
    input  logic                  i_ar_ready,
    output logic [ADDR_WIDTH-1:0] o_ar_addr,
    output logic [AR_LEN_W-1:0]   o_ar_len,
    input  logic                  i_r_valid,
    output logic                  o_r_ready,
    input  logic [DATA_WIDTH-1:0] i_r_data,
    input  logic                  i_r_last,
    output logic                  o_proto_err
);

    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
    localparam logic [TOTAL_W-1:0] MAX_BURST_BEATS = TOTAL_W'(MAX_BURST);

    rd_burst_state_t           r_state;
    rd_burst_state_t           w_nextState;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [TOTAL_W-1:0]        r_remain;
    logic [AR_LEN_W:0]         r_burstCount;
    logic                      r_arValid;
    logic [ADDR_WIDTH-1:0]     r_arAddr;
    logic [AR_LEN_W-1:0]       r_arLen;

    logic                      w_rdGnt;
    logic                      w_rReady;
    logic                      w_reqFire;
    logic                      w_arFire;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_burstLastBeat;
    logic                      w_burstEnd;
    logic                      w_fifoFull;
    logic                      w_fifoEmpty;
    logic [DATA_WIDTH:0]       w_fifoHead;
    logic [ADDR_WIDTH-1:0]     w_base;
    logic [TOTAL_W-1:0]        w_totalBeats;
    logic [ADDR_WIDTH-1:0]     w_srcAddr;
    logic [TOTAL_W-1:0]        w_srcRemain;
    logic [TOTAL_W-1:0]        w_nextBurst;
    logic [AR_LEN_W:0]         w_burstBeats;
    logic [ADDR_WIDTH-1:0]     w_burstBytes;

    assign w_reqFire       = i_rd_req && w_rdGnt;
    assign w_arFire        = r_arValid && i_ar_ready;
    assign w_push          = i_r_valid && w_rReady;
    assign w_pop           = !w_fifoEmpty && i_rd_ready;
    assign w_burstLastBeat = (r_burstCount == (AR_LEN_W + 1)'(1));
    assign w_burstEnd      = w_push && w_burstLastBeat;

    assign w_base       = (i_rd_addr >> BEAT_SHIFT) << BEAT_SHIFT;
    assign w_totalBeats = ceilBeats(i_rd_len, BYTES_PER_BEAT);

    // The first burst is sized from the incoming request, later ones from the running counters.
    assign w_srcAddr    = (r_state == IDLE) ? w_base : r_addr;
    assign w_srcRemain  = (r_state == IDLE) ? w_totalBeats : r_remain;
    assign w_nextBurst  = (w_srcRemain > MAX_BURST_BEATS) ? MAX_BURST_BEATS : w_srcRemain;
    assign w_burstBeats = {1'b0, r_arLen} + (AR_LEN_W + 1)'(1);
    assign w_burstBytes = ADDR_WIDTH'(w_burstBeats) << BEAT_SHIFT;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_rdGnt     = 1'b0;
        w_rReady    = 1'b0;
        case (r_state)
            IDLE: begin
                w_rdGnt = 1'b1;
                if (i_rd_req) begin
                    w_nextState = ADDR;
                end
            end
            ADDR: begin
                if (w_arFire) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                w_rReady = !w_fifoFull;
                if (w_burstEnd) begin
                    w_nextState = (r_remain != '0) ? ADDR : DRAIN;
                end
            end
            DRAIN: begin
                if (w_fifoEmpty) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // r_remain counts beats not yet requested on AR; r_burstCount counts beats still due in this burst.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr       <= '0;
            r_remain     <= '0;
            r_burstCount <= '0;
            r_arValid    <= 1'b0;
            r_arAddr     <= '0;
            r_arLen      <= '0;
        end else begin
            r_arValid <= (w_nextState == ADDR);
            if (w_reqFire) begin
                r_addr   <= w_base;
                r_remain <= w_totalBeats;
            end
            if ((w_nextState == ADDR) && (r_state != ADDR)) begin
                r_arAddr <= w_srcAddr;
                r_arLen  <= AR_LEN_W'(w_nextBurst - TOTAL_W'(1));
            end
            if (w_arFire) begin
                r_addr       <= r_arAddr + w_burstBytes;
                r_remain     <= r_remain - TOTAL_W'(w_burstBeats);
                r_burstCount <= w_burstBeats;
            end else if (w_push) begin
                r_burstCount <= r_burstCount - (AR_LEN_W + 1)'(1);
            end
        end
    end

    rd_data_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_push),
        .i_pushData ({w_burstLastBeat && (r_remain == '0), i_r_data}),
        .i_pop      (w_pop),
        .o_popData  (w_fifoHead),
        .o_full     (w_fifoFull),
        .o_empty    (w_fifoEmpty)
    );

    assign o_rd_gnt   = w_rdGnt;
    assign o_r_ready  = w_rReady;
    assign o_rd_valid = !w_fifoEmpty;
    assign o_rd_data  = w_fifoEmpty ? '0 : w_fifoHead[DATA_WIDTH-1:0];
    assign o_rd_done  = !w_fifoEmpty && w_fifoHead[DATA_WIDTH];
    assign o_ar_valid = r_arValid;
    assign o_ar_addr  = r_arAddr;
    assign o_ar_len   = r_arLen;

`ifdef RD_BURST_PROTO_CHK_EN
    logic r_protoErr;
    logic w_protoViolation;

    assign w_protoViolation = (w_push && (i_r_last != w_burstLastBeat)) ||
                              (i_r_valid && ((r_state == IDLE) || (r_state == ADDR)));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_protoErr <= 1'b0;
        end else if (w_protoViolation) begin
            r_protoErr <= 1'b1;
        end
    end

    assign o_proto_err = r_protoErr;
`else
    logic w_unusedRLast;
    assign w_unusedRLast = i_r_last;
    assign o_proto_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rd_burst_master.sv
// Directed bench for rd_burst_master: a small AR/R bus model feeds beats and
// every upstream beat, AR request and status flag is checked against hand values.
module tb_rd_burst_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int FD = 4;
    localparam logic [DW-1:0] DATA_BASE = 32'hC0DE_0000;

    logic          clk = 1'b0;
    logic          rstN;
    logic          rdReq;
    logic          rdGnt;
    logic [15:0]   rdLen;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] rdData;
    logic          rdValid;
    logic          rdReady;
    logic          rdDone;
    logic          arValid;
    logic          arReady;
    logic [AW-1:0] arAddr;
    logic [7:0]    arLen;
    logic          rValid;
    logic          rReady;
    logic [DW-1:0] rData;
    logic          rLast;
    logic          protoErr;

    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] expArAddr [4];
    logic [7:0]    expArLen [4];
    int            expArCount;
    logic          protoExpected = 1'b0;
    logic          sawFull = 1'b0;

    always #5 clk = ~clk;

    rd_burst_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .FIFO_DEPTH (FD)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_rd_req    (rdReq),
        .o_rd_gnt    (rdGnt),
        .i_rd_len    (rdLen),
        .i_rd_addr   (rdAddr),
        .o_rd_data   (rdData),
        .o_rd_valid  (rdValid),
        .i_rd_ready  (rdReady),
        .o_rd_done   (rdDone),
        .o_ar_valid  (arValid),
        .i_ar_ready  (arReady),
        .o_ar_addr   (arAddr),
        .o_ar_len    (arLen),
        .i_r_valid   (rValid),
        .o_r_ready   (rReady),
        .i_r_data    (rData),
        .i_r_last    (rLast),
        .o_proto_err (protoErr)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setArs(input int n, input logic [AW-1:0] a0, input logic [7:0] l0,
                          input logic [AW-1:0] a1, input logic [7:0] l1);
        expArCount   = n;
        expArAddr[0] = a0;
        expArLen[0]  = l0;
        expArAddr[1] = a1;
        expArLen[1]  = l1;
    endtask

    // readyMode 0 holds rd_ready high, 1 toggles it; resetAtBeat/lastErrBeat < 0 disable those events.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [15:0] len, input int totalBeats,
                                 input int readyMode, input int arDelay, input int resetAtBeat,
                                 input int lastErrBeat);
        int burstQ[$];
        int beatsLeft = 0;
        int rIdx = 0;
        int popIdx = 0;
        int occ = 0;
        int arIdx = 0;
        int arWait = 0;
        int cyc = 0;
        bit reqDone = 1'b0;
        bit doReset = 1'b0;
        bit gntSeen = 1'b0;
        while (popIdx < totalBeats && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (doReset) begin
                rstN    = 1'b0;
                rdReq   = 1'b0;
                rValid  = 1'b0;
                rLast   = 1'b0;
                rdReady = 1'b0;
                arReady = 1'b0;
                @(negedge clk);
                rstN = 1'b1;
                #1;
                checkOutput("rst_rd_valid", 64'(rdValid), 64'(0));
                checkOutput("rst_ar_valid", 64'(arValid), 64'(0));
                checkOutput("rst_r_ready", 64'(rReady), 64'(0));
                checkOutput("rst_rd_gnt", 64'(rdGnt), 64'(1));
                checkOutput("rst_rd_done", 64'(rdDone), 64'(0));
                protoExpected = 1'b0;
                return;
            end
            rdReq   = !reqDone;
            rdAddr  = addr;
            rdLen   = len;
            arReady = (arWait >= arDelay);
            if (beatsLeft == 0 && burstQ.size() > 0) begin
                beatsLeft = burstQ.pop_front();
            end
            rValid  = (beatsLeft > 0);
            rData   = DATA_BASE + DW'(rIdx);
            rLast   = (beatsLeft == 1) || (rIdx == lastErrBeat);
            rdReady = (readyMode == 0) ? 1'b1 : cyc[0];
            #1;
            checkOutput("rd_valid_occ", 64'(rdValid), 64'(occ > 0));
            if (occ == FD) begin
                checkOutput("r_ready_full", 64'(rReady), 64'(0));
                sawFull = 1'b1;
            end
            checkOutput("proto_err", 64'(protoErr), 64'(protoExpected));
            if (reqDone) begin
                checkOutput("rd_gnt_busy", 64'(rdGnt), 64'(0));
            end else if (cyc == 1) begin
                checkOutput("rd_gnt_idle", 64'(rdGnt), 64'(1));
            end
            if (rdValid) begin
                checkOutput("rd_data", 64'(rdData), 64'(DATA_BASE + DW'(popIdx)));
                checkOutput("rd_done", 64'(rdDone), 64'(popIdx == totalBeats - 1));
            end
            if (!reqDone && rdGnt) begin
                reqDone = 1'b1;
            end
            if (arWait > 0) begin
                checkOutput("ar_hold", 64'(arValid), 64'(1));
            end
            if (arValid) begin
                if (arIdx < expArCount) begin
                    checkOutput("ar_addr", 64'(arAddr), 64'(expArAddr[arIdx]));
                    checkOutput("ar_len", 64'(arLen), 64'(expArLen[arIdx]));
                    if (arReady) begin
                        burstQ.push_back(int'(expArLen[arIdx]) + 1);
                        arIdx++;
                        arWait = 0;
                    end else begin
                        arWait++;
                    end
                end else begin
                    checkOutput("ar_extra", 64'(1), 64'(0));
                end
            end
            if (rValid && rReady) begin
                beatsLeft--;
`ifdef RD_BURST_PROTO_CHK_EN
                if (rIdx == lastErrBeat) begin
                    protoExpected = 1'b1;
                end
`endif
                rIdx++;
                occ++;
                if (resetAtBeat >= 0 && rIdx == resetAtBeat) begin
                    doReset = 1'b1;
                end
            end
            if (rdValid && rdReady) begin
                popIdx++;
                occ--;
            end
        end
        checkOutput("beats_delivered", 64'(popIdx), 64'(totalBeats));
        checkOutput("ar_count", 64'(arIdx), 64'(expArCount));
        for (int k = 0; k < 4 && !gntSeen; k++) begin
            @(negedge clk);
            rdReq   = 1'b0;
            rValid  = 1'b0;
            rLast   = 1'b0;
            rdReady = 1'b1;
            #1;
            gntSeen = rdGnt;
        end
        checkOutput("rd_gnt_return", 64'(gntSeen), 64'(1));
        checkOutput("idle_rd_valid", 64'(rdValid), 64'(0));
    endtask

    initial begin
        rstN    = 1'b0;
        rdReq   = 1'b0;
        rdLen   = '0;
        rdAddr  = '0;
        rdReady = 1'b0;
        arReady = 1'b0;
        rValid  = 1'b0;
        rData   = '0;
        rLast   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_rd_gnt", 64'(rdGnt), 64'(1));
        checkOutput("reset_rd_valid", 64'(rdValid), 64'(0));
        checkOutput("reset_rd_data", 64'(rdData), 64'(0));
        checkOutput("reset_ar_valid", 64'(arValid), 64'(0));
        checkOutput("reset_ar_addr", 64'(arAddr), 64'(0));
        checkOutput("reset_ar_len", 64'(arLen), 64'(0));
        checkOutput("reset_r_ready", 64'(rReady), 64'(0));
        checkOutput("reset_proto_err", 64'(protoErr), 64'(0));
        rstN = 1'b1;

        $display("[TB] 128-byte line, full throughput");
        setArs(2, 32'h0000_1000, 8'd15, 32'h0000_1040, 8'd15);
        applyStimulus(32'h0000_1000, 16'd128, 32, 0, 0, -1, -1);

        $display("[TB] 128-byte line, rd_ready toggling");
        sawFull = 1'b0;
        applyStimulus(32'h0000_1000, 16'd128, 32, 1, 0, -1, -1);
        checkOutput("fifo_reached_full", 64'(sawFull), 64'(1));

        $display("[TB] unaligned 5-byte read, ar_ready delayed");
        setArs(1, 32'h0000_1000, 8'd1, 32'h0, 8'd0);
        applyStimulus(32'h0000_1003, 16'd5, 2, 0, 2, -1, -1);

        $display("[TB] zero-length read");
        setArs(1, 32'h0000_2000, 8'd0, 32'h0, 8'd0);
        applyStimulus(32'h0000_2000, 16'd0, 1, 0, 0, -1, -1);

        $display("[TB] address wrap across top of memory");
        setArs(2, 32'hFFFF_FFC0, 8'd15, 32'h0000_0000, 8'd15);
        applyStimulus(32'hFFFF_FFC0, 16'd128, 32, 0, 0, -1, -1);

        $display("[TB] reset during second burst, then fresh request");
        setArs(2, 32'h0000_1000, 8'd15, 32'h0000_1040, 8'd15);
        applyStimulus(32'h0000_1000, 16'd128, 32, 0, 0, 20, -1);
        setArs(2, 32'h0000_3004, 8'd15, 32'h0000_3044, 8'd1);
        applyStimulus(32'h0000_3004, 16'd72, 18, 0, 0, -1, -1);

`ifdef RD_BURST_PROTO_CHK_EN
        $display("[TB] early r_last on beat 3 of first burst");
        setArs(2, 32'h0000_1000, 8'd15, 32'h0000_1040, 8'd15);
        applyStimulus(32'h0000_1000, 16'd128, 32, 0, 0, -1, 2);
        checkOutput("proto_err_sticky", 64'(protoErr), 64'(1));
`else
        checkOutput("proto_err_tied", 64'(protoErr), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
